// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1: N-channel, W-bit valid/ready stream multiplexer with one
// output register stage. The grant comes either from an external select
// (manual, mode=0) or from a round-robin scan over valid channels (mode=1).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_data    NCH*WIDTH packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept, one-hot or zero
//   mode       0 = manual (sel), 1 = round-robin scan
//   sel        manual channel index
//   out_data   registered selected word
//   out_ch     channel index that produced out_data
//   out_valid  out_data/out_ch hold a word
//   out_ready  consumer accepts the word this cycle
module mux_stream_nto1 #(
   parameter int unsigned  WIDTH = 8,
   parameter int unsigned  NCH   = 8,
   localparam int unsigned SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*WIDTH-1:0]   in_data,
   input  logic [NCH-1:0]         in_valid,
   output logic [NCH-1:0]         in_ready,
   input  logic                   mode,
   input  logic [SELW-1:0]        sel,
   output logic [WIDTH-1:0]       out_data,
   output logic [SELW-1:0]        out_ch,
   output logic                   out_valid,
   input  logic                   out_ready
);

   logic [WIDTH-1:0] out_data_q,  out_data_d;
   logic [SELW-1:0]  out_ch_q,    out_ch_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  rr_last_q,   rr_last_d;

   logic             load_en;
   logic             grant_ok;
   logic [SELW-1:0]  grant;
   logic [WIDTH-1:0] grant_word;
   logic             xfer;

   logic [SELW-1:0]  scan_hi;
   logic [SELW-1:0]  scan_lo;
   logic             found_hi;
   logic             found_lo;

   // Output register accepts a new word when empty or being drained.
   assign load_en = !out_valid_q || out_ready;

   // Grant selection. Scan mode splits the ring into channels above rr_last
   // (searched first) and channels at or below it (the wrap-around part).
   // Manual mode matches sel against real channel indices only, so an
   // out-of-range sel simply finds no channel.
   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      scan_hi  = '0;
      scan_lo  = '0;
      found_hi = 1'b0;
      found_lo = 1'b0;
      if (!mode) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (sel == SELW'(i)) begin
               grant    = SELW'(i);
               grant_ok = in_valid[i];
            end
         end
      end else begin
         for (int unsigned i = 0; i < NCH; i++) begin
            if (in_valid[i]) begin
               if ((SELW'(i) > rr_last_q) && !found_hi) begin
                  scan_hi  = SELW'(i);
                  found_hi = 1'b1;
               end
               if ((SELW'(i) <= rr_last_q) && !found_lo) begin
                  scan_lo  = SELW'(i);
                  found_lo = 1'b1;
               end
            end
         end
         grant    = found_hi ? scan_hi : scan_lo;
         grant_ok = found_hi || found_lo;
      end
   end

   // Granted word mux; compare-and-select keeps out-of-range grants X-free.
   always_comb begin
      grant_word = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (grant == SELW'(i)) begin
            grant_word = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign xfer = load_en && grant_ok;

   // One-hot accept toward the granted channel, forced low during reset.
   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         in_ready[i] = rst_n && xfer && (grant == SELW'(i));
      end
   end

   // Next state of the output stage and round-robin pointer.
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = out_valid_q;
      rr_last_d   = rr_last_q;
      if (load_en) begin
         if (grant_ok) begin
            out_data_d  = grant_word;
            out_ch_d    = grant;
            out_valid_d = 1'b1;
            if (mode) begin
               rr_last_d = grant;
            end
         end else begin
            out_valid_d = 1'b0;
         end
      end
   end

   // State registers; reset parks rr_last so the first scan starts at ch0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         rr_last_q   <= SELW'(NCH - 1);
      end else begin
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         rr_last_q   <= rr_last_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_stream_nto1.sv
// Self-checking bench for mux_stream_nto1: an 8-channel instance checked
// against a transaction-level reference model, plus a 5-channel instance for
// out-of-range select and mid-transfer reset.
module tb_mux_stream_nto1;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 8-channel instance
   logic        rst_n;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic        mode;
   logic [2:0]  sel;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   // 5-channel instance
   logic        rst5_n;
   logic [39:0] in_data5;
   logic [4:0]  in_valid5;
   logic [4:0]  in_ready5;
   logic        mode5;
   logic [2:0]  sel5;
   logic [7:0]  out_data5;
   logic [2:0]  out_ch5;
   logic        out_valid5;
   logic        out_ready5;

   mux_stream_nto1 #(.WIDTH(8), .NCH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
   );

   mux_stream_nto1 #(.WIDTH(8), .NCH(5)) dut5 (
      .clk(clk), .rst_n(rst5_n), .in_data(in_data5), .in_valid(in_valid5),
      .in_ready(in_ready5), .mode(mode5), .sel(sel5), .out_data(out_data5),
      .out_ch(out_ch5), .out_valid(out_valid5), .out_ready(out_ready5)
   );

   int nchk  = 0;
   int nfail = 0;

   // Channel words for the 8-channel instance
   logic [7:0] w [8];

   // Reference model: contents of the output register and the scan pointer
   logic       mv;
   logic [7:0] md;
   int         mch;
   int         mrr;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pack();
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = w[i];
   endtask

   // Grant rule: manual uses sel; scan walks rr+1, rr+2, ... modulo 8.
   task automatic model_grant(output logic ok, output int g);
      ok = 1'b0;
      g  = 0;
      if (!mode) begin
         g  = int'(sel);
         ok = (g < 8) && in_valid[g];
      end else begin
         for (int k = 1; k <= 8; k++) begin
            if (!ok && in_valid[(mrr + k) % 8]) begin
               g  = (mrr + k) % 8;
               ok = 1'b1;
            end
         end
      end
   endtask

   // One clock: check in_ready before the edge, advance model, check outputs.
   task automatic cycle();
      logic       ok;
      int         g;
      logic       load;
      logic [7:0] er;
      pack();
      #1;
      model_grant(ok, g);
      load = !mv || out_ready;
      er   = (rst_n && load && ok) ? 8'(1 << g) : 8'h00;
      check("in_ready", 64'(in_ready), 64'(er));
      @(posedge clk);
      if (!rst_n) begin
         mv = 1'b0; md = 8'h00; mch = 0; mrr = 7;
      end else if (load) begin
         if (ok) begin
            mv = 1'b1; md = w[g]; mch = g;
            if (mode) mrr = g;
         end else begin
            mv = 1'b0;
         end
      end
      #1;
      check("out_valid", 64'(out_valid), 64'(mv));
      if (mv) begin
         check("out_data", 64'(out_data), 64'(md));
         check("out_ch", 64'(out_ch), 64'(mch));
      end
   endtask

   initial begin
      rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) w[i] = 8'(8'h10 + i);
      mv = 1'b0; md = 8'h00; mch = 0; mrr = 7;
      rst5_n = 1'b0; in_data5 = '0; in_valid5 = '0; mode5 = 1'b0; sel5 = 3'd0; out_ready5 = 1'b1;
      @(posedge clk); #1;

      // Reset held with all inputs valid
      cycle();
      cycle();
      check("rst out_data", 64'(out_data), 64'h00);
      check("rst out_ch", 64'(out_ch), 64'h0);
      check("rst out_valid", 64'(out_valid), 64'h0);

      // Scan, all valid: order 0..7,0,1 at one word per cycle
      rst_n = 1'b1;
      for (int n = 0; n < 10; n++) begin
         for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
         cycle();
         check("scan order", 64'(out_ch), 64'(n % 8));
      end

      // Manual sel=3
      mode = 1'b0; sel = 3'd3; in_valid = 8'h08; w[3] = 8'hA5;
      pack(); #1;
      check("man rdy", 64'(in_ready), 64'h08);
      cycle();
      check("man data", 64'(out_data), 64'hA5);
      check("man ch", 64'(out_ch), 64'h3);
      // Manual sel=5 with ch5 idle: word retires, nothing loads
      sel = 3'd5;
      cycle();
      check("man idle", 64'(out_valid), 64'h0);

      // Set rr_last=2, then ch7/ch2 alternate with wrap
      mode = 1'b1; in_valid = 8'h04;
      cycle();
      in_valid = 8'h84;
      cycle(); check("wrap 7a", 64'(out_ch), 64'h7);
      cycle(); check("wrap 2", 64'(out_ch), 64'h2);
      cycle(); check("wrap 7b", 64'(out_ch), 64'h7);

      // Backpressure holding 3C, then drain and load on the same edge
      mode = 1'b0; sel = 3'd1; in_valid = 8'h02; w[1] = 8'h3C;
      cycle();
      out_ready = 1'b0;
      for (int n = 0; n < 4; n++) begin
         w[1] = 8'($urandom);
         cycle();
         check("bp hold", 64'(out_data), 64'h3C);
      end
      out_ready = 1'b1; w[1] = 8'h5A;
      cycle();
      check("bp v", 64'(out_valid), 64'h1);
      check("bp load", 64'(out_data), 64'h5A);

      // 5-channel instance: out-of-range select, then reset while holding
      in_valid = 8'h00;
      rst5_n = 1'b1; mode5 = 1'b0; sel5 = 3'd6; in_valid5 = 5'h1F; in_data5 = 40'h44_33_22_11_00;
      #1;
      check("n5 rdy", 64'(in_ready5), 64'h0);
      cycle();
      check("n5 valid", 64'(out_valid5), 64'h0);
      check("n5 noX", 64'($isunknown(out_data5)), 64'h0);
      sel5 = 3'd2;
      cycle();
      check("n5 load v", 64'(out_valid5), 64'h1);
      check("n5 load d", 64'(out_data5), 64'h22);
      out_ready5 = 1'b0; rst5_n = 1'b0;
      cycle();
      check("n5 rst", 64'(out_valid5), 64'h0);
      rst5_n = 1'b1;

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         rst_n     = ($urandom_range(0, 49) != 0);
         mode      = 1'(($urandom_range(0, 3) != 0));
         sel       = 3'($urandom);
         in_valid  = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'($urandom & $urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 8; i++) w[i] = 8'($urandom);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/mux_stream_nto1.md
Name: mux_stream_nto1

Overview:
Parametrised N-channel, W-bit stream multiplexer. It is the registered, handshaked successor of the 8:1 behavioural mux. Each input channel carries a valid/ready stream. A per-cycle grant picks one channel, either from an external select (manual mode) or from a round-robin scan over channels with valid data (scan mode). The granted word goes through a single output register stage with its own valid/ready handshake. It sits between parallel producers (sensor lanes, ALU result ports) and a single shared consumer.

Parameters:
WIDTH, 8, data bits per channel
NCH, 8, number of input channels (2..64, need not be a power of two)
SELW, $clog2(NCH), width of select and channel-tag fields (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel data valid
in_ready  output  NCH  per-channel accept; at most one bit high per cycle
mode  input  1  0 = manual (use sel), 1 = round-robin scan
sel  input  SELW  channel index used in manual mode
out_data  output  WIDTH  registered selected word
out_ch  output  SELW  index of the channel that produced out_data
out_valid  output  1  out_data/out_ch hold a word
out_ready  input  1  consumer accepts the word this cycle

Behaviour:
- Reset: synchronous; sampled on a clk edge with rst_n=0. Reset values are out_valid=0, out_data=0, out_ch=0, rr_last=NCH-1. in_ready is all zero while rst_n=0. Reset mid-transfer discards the held word with no completion.
- load_en = !out_valid || out_ready. This is a single-register pipeline with full throughput: one word per cycle when out_ready stays high.
- Grant (combinational):
  - manual: grant = sel. grant_ok = (sel < NCH) && in_valid[sel].
  - scan: search channels rr_last+1, rr_last+2, ... modulo NCH, wrapping. grant is the first channel with in_valid=1. grant_ok = |in_valid.
- in_ready[i] = load_en && grant_ok && (i == grant). in_ready never depends on out_data.
- Transfer on the edge where in_valid[grant] && in_ready[grant]:
  - out_data <= granted word; out_ch <= grant; out_valid <= 1.
  - In scan mode, rr_last <= grant. rr_last does not update in manual mode.
- If load_en=1 and no transfer occurs, out_valid <= 0 (the consumed word retires).
- While out_valid=1 and out_ready=0:
  - out_data and out_ch are held stable.
  - All in_ready bits are 0.
- Latency: one cycle from input transfer to out_valid.
- Out-of-range sel (sel >= NCH, only possible when NCH is not a power of two): no grant, all in_ready=0, no X propagation. Replaces the legacy default-to-x arm.
- Mode or sel change: takes effect at the next grant evaluation. A word already in the output register is unaffected. Switching to scan continues from the current rr_last.
- Fairness: in scan mode with every channel continuously valid and out_ready=1, the grant order is 0,1,…,NCH-1,0,… with no channel starved.
- Simultaneous out_ready=1 and a new grant in the same cycle: the old word retires and the new word loads on that edge. No bubble.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=8'hFF -> out_valid=0, out_data=0, out_ch=0, in_ready=0. Release reset, mode=1 -> first word from ch0.
2. Manual mode, WIDTH=8, NCH=8, sel=3, in_data ch3=8'hA5, in_valid[3]=1, out_ready=1 -> in_ready=8'h08. Next cycle out_data=8'hA5, out_ch=3, out_valid=1. Also drive sel=5 with in_valid[5]=0 -> in_ready=0 and out_valid drops after retiring.
3. Scan, all channels valid, out_ready=1 for 10 cycles -> out_ch sequence 0,1,…,7,0,1 at one word per cycle.
4. Scan, in_valid=8'b1000_0100 and rr_last=2 -> grant ch7, then ch2 (wrap), then ch7.
5. Backpressure: out_valid=1 holding 8'h3C, out_ready=0 for 4 cycles -> out_data stays 8'h3C, in_ready=0. Then out_ready=1 with ch1 valid -> 8'h3C retires and the ch1 word loads on the same edge.
6. NCH=5 build: sel=6 in manual mode -> in_ready=0 and out_data never X. Assert rst_n=0 while out_valid=1 -> out_valid=0 next edge.
